// File: rtl/vmu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vmu_pkg
// Description : Shared types, default geometry and helpers for the vector
//               memory unit.
// Revision    : 1.0 - initial release
// ============================================================================
package vmu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam int          VMU_N        = 32;
    localparam int          VMU_LANES    = 4;
    localparam logic [31:0] VMU_ADDR_MAX = 32'h0003_D08F;
    localparam int          VMU_V        = VMU_N * VMU_LANES;
    localparam int          VMU_IDX_W    = (VMU_LANES > 1) ? $clog2(VMU_LANES) : 1;

    // Extract lane idx (N bits) from a packed V-bit vector.
    function automatic logic [VMU_N-1:0] lane_slice(input logic [VMU_V-1:0]     vec,
                                                    input logic [VMU_IDX_W-1:0] idx);
        return vec[idx*VMU_N +: VMU_N];
    endfunction

endpackage
`default_nettype wire

// File: rtl/vmu_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : vmu_addr_gen
// Description : Lane address generator with out-of-range guard.
//               addr = base + idx*step (modulo 2^N); in_range = addr <= ADDR_MAX.
// Revision    : 1.0 - initial release
// ============================================================================
module vmu_addr_gen #(
    parameter int          N        = 32,
    parameter int          IDX_W    = 2,
    parameter logic [N-1:0] ADDR_MAX = 32'h0003_D08F
) (
    input  logic [N-1:0]     i_base,
    input  logic [N-1:0]     i_step,
    input  logic [IDX_W-1:0] i_idx,
    output logic [N-1:0]     o_addr,
    output logic             o_in_range
);

    logic [N-1:0] w_offset;

    // Offset and sum are truncated to N bits, so wrap-around is intentional.
    assign w_offset   = {{(N-IDX_W){1'b0}}, i_idx} * i_step;
    assign o_addr     = i_base + w_offset;
    assign o_in_range = (o_addr <= ADDR_MAX);

endmodule
`default_nettype wire

// File: rtl/vector_mem_unit.sv
`default_nettype none
// ============================================================================
// Module      : vector_mem_unit
// Description : Memory stage for the vector pipeline. Scalar accesses pass
//               straight through; a vector access is serialised into LANES
//               single-word accesses while the pipeline is stalled.
// Revision    : 1.0 - initial release
// ============================================================================
module vector_mem_unit
    import vmu_pkg::*;
#(
    parameter int           N        = VMU_N,
    parameter int           LANES    = VMU_LANES,
    parameter logic [N-1:0] ADDR_MAX = VMU_ADDR_MAX
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req,
    input  logic                 vect,
    input  logic                 we,
    input  logic                 stride_en,
    input  logic [N-1:0]         base_addr,
    input  logic [N-1:0]         stride,
    input  logic [N*LANES-1:0]   wdata,
    input  logic [N-1:0]         mem_rdata,
    output logic [N-1:0]         mem_addr,
    output logic [N-1:0]         mem_wdata,
    output logic                 mem_we,
    output logic [N*LANES-1:0]   rdata,
    output logic                 stall,
    output logic                 done,
    output logic                 range_err
);

    localparam int               V           = N * LANES;
    localparam int               IDX_W       = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [IDX_W-1:0] c_LAST_IDX  = IDX_W'(LANES - 1);
    localparam logic [N-1:0]     c_UNIT_STEP = N'(N / 8);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDX_W-1:0] r_idx;
    logic [N-1:0]     r_base;
    logic [N-1:0]     r_step;
    logic [V-1:0]     r_wdata;
    logic             r_we;
    logic             r_err;
    logic [V-1:0]     r_rdata;

    logic [N-1:0]     w_gen_base;
    logic [IDX_W-1:0] w_gen_idx;
    logic [N-1:0]     w_addr;
    logic             w_in_range;
    logic [N-1:0]     w_addr_guarded;
    logic [N-1:0]     w_rd_guarded;

    // One generator serves both paths: live base in IDLE (scalar), latched operands otherwise.
    always_comb begin
        w_gen_base = (r_state == IDLE) ? base_addr : r_base;
        w_gen_idx  = (r_state == IDLE) ? '0 : r_idx;
    end

    vmu_addr_gen #(
        .N        (N),
        .IDX_W    (IDX_W),
        .ADDR_MAX (ADDR_MAX)
    ) u_addr_gen (
        .i_base     (w_gen_base),
        .i_step     (r_step),
        .i_idx      (w_gen_idx),
        .o_addr     (w_addr),
        .o_in_range (w_in_range)
    );

    assign w_addr_guarded = w_in_range ? w_addr : '0;
    assign w_rd_guarded   = w_in_range ? mem_rdata : '0;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and output decode; reset forces all outputs to their idle values.
    always_comb begin
        w_state_nxt = r_state;
        mem_addr    = '0;
        mem_wdata   = '0;
        mem_we      = 1'b0;
        rdata       = r_rdata;
        stall       = 1'b0;
        done        = 1'b0;
        range_err   = 1'b0;
        if (!rst) begin
            case (r_state)
                IDLE: begin
                    if (req && vect) begin
                        stall       = 1'b1;
                        w_state_nxt = ACCESS;
                    end else if (req) begin
                        mem_addr  = w_addr_guarded;
                        mem_wdata = wdata[N-1:0];
                        mem_we    = we & w_in_range;
                        rdata     = {{(V-N){1'b0}}, w_rd_guarded};
                    end
                end
                ACCESS: begin
                    stall     = 1'b1;
                    mem_addr  = w_addr_guarded;
                    mem_wdata = lane_slice(r_wdata, r_idx);
                    mem_we    = r_we & w_in_range;
                    if (r_idx == c_LAST_IDX) begin
                        w_state_nxt = DONE;
                    end
                end
                DONE: begin
                    // req is still the same instruction here, so it is ignored.
                    done        = 1'b1;
                    range_err   = r_err;
                    w_state_nxt = IDLE;
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    // Operand latching, lane sequencing, load capture and sticky range error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx   <= '0;
            r_base  <= '0;
            r_step  <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req && vect) begin
                        r_base  <= base_addr;
                        r_step  <= stride_en ? stride : c_UNIT_STEP;
                        r_wdata <= wdata;
                        r_we    <= we;
                        r_idx   <= '0;
                        r_err   <= 1'b0;
                    end
                end
                ACCESS: begin
                    if (!w_in_range) begin
                        r_err <= 1'b1;
                    end
                    if (!r_we) begin
                        r_rdata[r_idx*N +: N] <= w_rd_guarded;
                    end
                    if (r_idx != c_LAST_IDX) begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire
